// File: rtl/insn_encoder.sv
// insn_encoder: packs symbolic RV32I requests into words and streams them into instruction memory.
// Define INSN_ENC_RANGE_CHK_EN to reject out-of-range immediates (otherwise they are truncated).
module insn_encoder #(
  parameter int ADDR_W = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_end,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic [4:0]        i_op,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_imem_wren,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_done
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic acc, bad;
  logic is_r, is_i, is_sh, is_lw, is_sw, is_b, is_u, is_jalr;
  logic [2:0] f3;
  logic [6:0] i_opc;
  logic [11:0] i_fld;
  logic [31:0] r_w, i_w, s_w, b_w, u_w, j_w, word;
  assign o_req_rdy = state == LOAD && !o_full;
  assign acc = i_req_vld && o_req_rdy;
  assign o_busy = state == LOAD;
  assign o_done = state == DONE;
  assign is_r = i_op <= 5'd9;
  assign is_i = i_op >= 5'd10 && i_op <= 5'd18;
  assign is_sh = i_op >= 5'd16 && i_op <= 5'd18;
  assign is_lw = i_op == 5'd19;
  assign is_sw = i_op == 5'd20;
  assign is_b = i_op >= 5'd21 && i_op <= 5'd26;
  assign is_u = i_op == 5'd27 || i_op == 5'd28;
  assign is_jalr = i_op == 5'd30;
  always_comb begin
    case (i_op)
      5'd2, 5'd16, 5'd22:               f3 = 3'b001;
      5'd3, 5'd11, 5'd19, 5'd20:        f3 = 3'b010;
      5'd4, 5'd12:                      f3 = 3'b011;
      5'd5, 5'd13, 5'd23:               f3 = 3'b100;
      5'd6, 5'd7, 5'd17, 5'd18, 5'd24:  f3 = 3'b101;
      5'd8, 5'd14, 5'd25:               f3 = 3'b110;
      5'd9, 5'd15, 5'd26:               f3 = 3'b111;
      default:                          f3 = 3'b000;
    endcase
  end
  assign i_opc = is_lw ? 7'b0000011 : is_jalr ? 7'b1100111 : 7'b0010011;
  assign i_fld = is_sh ? {(i_op == 5'd18) ? 7'h20 : 7'h00, i_imm[4:0]} : i_imm[11:0];
  assign r_w = {(i_op == 5'd1 || i_op == 5'd7) ? 7'h20 : 7'h00, i_rs2, i_rs1, f3, i_rd, 7'b0110011};
  assign i_w = {i_fld, i_rs1, f3, i_rd, i_opc};
  assign s_w = {i_imm[11:5], i_rs2, i_rs1, f3, i_imm[4:0], 7'b0100011};
  assign b_w = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, f3, i_imm[4:1], i_imm[11], 7'b1100011};
  assign u_w = {i_imm[31:12], i_rd, (i_op == 5'd27) ? 7'b0110111 : 7'b0010111};
  assign j_w = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, 7'b1101111};
  assign word = is_r ? r_w : (is_i || is_lw || is_jalr) ? i_w : is_sw ? s_w :
                is_b ? b_w : is_u ? u_w : j_w;
`ifdef INSN_ENC_RANGE_CHK_EN
  logic s12, s13, s21;
  assign s12 = &i_imm[31:11] || ~|i_imm[31:11];
  assign s13 = &i_imm[31:12] || ~|i_imm[31:12];
  assign s21 = &i_imm[31:20] || ~|i_imm[31:20];
  assign bad = &i_op || (((is_i && !is_sh) || is_lw || is_sw || is_jalr) && !s12) ||
               (is_sh && |i_imm[31:5]) || (is_b && (i_imm[0] || !s13)) ||
               (i_op == 5'd29 && (i_imm[0] || !s21)) || (is_u && |i_imm[11:0]);
`else
  assign bad = &i_op;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= BASE;
      o_count <= '0;
      o_err <= 1'b0;
      o_full <= 1'b0;
      o_imem_wren <= 1'b0;
      o_imem_addr <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_wren <= acc;
      if (state != LOAD && i_start) begin
        state <= LOAD;
        ptr <= BASE;
        o_count <= '0;
        o_err <= 1'b0;
        o_full <= 1'b0;
      end else if (state == LOAD) begin
        if (acc) begin
          o_imem_addr <= ptr;
          o_imem_wdata <= bad ? NOP : word;
          o_count <= o_count + (ADDR_W + 1)'(1);
          o_err <= o_err || bad;
          o_full <= ptr == LAST;
          if (ptr != LAST) ptr <= ptr + ADDR_W'(1);
        end
        if (i_end || o_full) state <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed vectors for insn_encoder (default build and a tiny 4-word instance).
module tb_insn_encoder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, end_ld = 1'b0, vld = 1'b0;
  logic [4:0] op = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic rdy, wren, err, full, busy, done;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [11:0] count;
  logic rdy1, wren1, err1, full1, busy1, done1;
  logic [1:0] addr1;
  logic [31:0] wdata1;
  logic [2:0] count1;
  int errors = 0, checks = 0;
`ifdef INSN_ENC_RANGE_CHK_EN
  localparam logic [31:0] BIG_W = 32'h0000_0013;
  localparam logic [31:0] BIG_E = 32'd1;
`else
  localparam logic [31:0] BIG_W = 32'h8000_0013;
  localparam logic [31:0] BIG_E = 32'd0;
`endif

  always #5 clk = ~clk;

  insn_encoder u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_end(end_ld), .i_req_vld(vld),
    .o_req_rdy(rdy), .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_imem_wren(wren), .o_imem_addr(addr), .o_imem_wdata(wdata), .o_count(count),
    .o_err(err), .o_full(full), .o_busy(busy), .o_done(done)
  );

  insn_encoder #(.ADDR_W(2), .BASE_ADDR(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_end(end_ld), .i_req_vld(vld),
    .o_req_rdy(rdy1), .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_imem_wren(wren1), .o_imem_addr(addr1), .o_imem_wdata(wdata1), .o_count(count1),
    .o_err(err1), .o_full(full1), .o_busy(busy1), .o_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [4:0] o, input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic [31:0] im);
    vld = 1'b1; op = o; rd = d; rs1 = a; rs2 = b; imm = im;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step(); step();
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {27'd0, rdy, err, full, busy, done}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", 32'(rdy), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy_rdy", {30'd0, busy, rdy}, 32'h3);
    req(5'd0, 5'd3, 5'd1, 5'd2, 0); step(); vld = 1'b0;
    chk("add_wren", 32'(wren), 1);
    chk("add_addr", 32'(addr), 0);
    chk("add_wdata", wdata, 32'h0020_81B3);
    chk("add_count", 32'(count), 1);
    step();
    chk("idle_wren", 32'(wren), 0);
    chk("hold_wdata", wdata, 32'h0020_81B3);
    end_ld = 1'b1; step(); end_ld = 1'b0;
    chk("end_done", {30'd0, busy, done}, 32'h1);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_count", 32'(count), 0);
    req(5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF); step();
    chk("addi_w", wdata, 32'hFFF0_0093);
    chk("addi_a", 32'(addr), 0);
    req(5'd20, 5'd0, 5'd2, 5'd5, 32'd8); step();
    chk("sw_w", wdata, 32'h0051_2423);
    chk("sw_a", 32'(addr), 1);
    chk("sw_wren", 32'(wren), 1);
    req(5'd21, 5'd0, 5'd0, 5'd0, -32'sd4); step();
    chk("beq_w", wdata, 32'hFE00_0EE3);
    chk("beq_a", 32'(addr), 2);
    req(5'd18, 5'd1, 5'd2, 5'd0, 32'd3); step();
    chk("srai_w", wdata, 32'h4031_5093);
    req(5'd27, 5'd5, 5'd0, 5'd0, 32'h1234_5000); step();
    chk("lui_w", wdata, 32'h1234_52B7);
    req(5'd29, 5'd1, 5'd0, 5'd0, 32'd8); step();
    chk("jal_w", wdata, 32'h0080_00EF);
    chk("clean_err", 32'(err), 0);
    req(5'd10, 5'd0, 5'd0, 5'd0, 32'd2048); step(); vld = 1'b0;
    chk("big_w", wdata, BIG_W);
    chk("big_err", 32'(err), BIG_E);
    step();
    chk("big_err_sticky", 32'(err), BIG_E);
    req(5'd31, 5'd1, 5'd1, 5'd1, 32'd0); step(); vld = 1'b0;
    chk("ill_w", wdata, 32'h0000_0013);
    chk("ill_err", 32'(err), 1);
    chk("ill_count", 32'(count), 8);
    req(5'd0, 5'd3, 5'd1, 5'd2, 0); end_ld = 1'b1; step(); vld = 1'b0; end_ld = 1'b0;
    chk("endreq_wren", 32'(wren), 1);
    chk("endreq_w", wdata, 32'h0020_81B3);
    chk("endreq_done", 32'(done), 1);
    start = 1'b1; step(); start = 1'b0;
    chk("restart2_busy", 32'(busy), 1);
    chk("restart2_count_err", {20'd0, count}, 0);
    chk("restart2_err", 32'(err), 0);
    req(5'd0, 5'd3, 5'd1, 5'd2, 0); step(); vld = 1'b0;
    chk("restart2_addr", 32'(addr), 0);
    req(5'd0, 5'd3, 5'd1, 5'd2, 0);
    @(posedge clk); #1 rst_n = 1'b0; vld = 1'b0;
    #1;
    chk("abort_wren", 32'(wren), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_state", {30'd0, busy, done}, 0);
    step(); rst_n = 1'b1; step();
    chk("abort_rdy", 32'(rdy), 0);
    start = 1'b1; step(); start = 1'b0;
    req(5'd0, 5'd3, 5'd1, 5'd2, 0); step();
    chk("full_a1", 32'(addr1), 1);
    step();
    chk("full_a2", 32'(addr1), 2);
    step();
    chk("full_a3", 32'(addr1), 3);
    chk("full_wren", 32'(wren1), 1);
    chk("full_flags", {30'd0, full1, rdy1}, 32'h2);
    step();
    chk("full_done", 32'(done1), 1);
    chk("full_nowrite", 32'(wren1), 0);
    chk("full_count", 32'(count1), 3);
    vld = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
